// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multi-cycle control unit for the NPC core. Latches each fetched
//            instruction, decodes the datapath control bundle and sequences
//            it through FETCH/DECODE/EXEC/MEM/WB with IFU/LSU/MDU handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int XLEN      = 32,
    parameter bit EN_M      = 1'b0,
    parameter int ALU_SEL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 ifu_req,
    input  logic                 ifu_rvalid,
    input  logic [31:0]          inst,
    output logic                 lsu_req,
    output logic                 lsu_wen,
    input  logic                 lsu_rvalid,
    output logic                 exu_start,
    input  logic                 exu_done,
    output logic [2:0]           op_IMM,
    output logic                 op_ALU_Asrc,
    output logic [1:0]           op_ALU_Bsrc,
    output logic [ALU_SEL_W-1:0] op_ALU_sel,
    output logic                 branch,
    output logic                 load,
    output logic                 en_Wmem,
    output logic                 word_op,
    output logic                 mdu_op,
    output logic [2:0]           mdu_fn,
    output logic                 en_Wreg,
    output logic                 pc_we,
    output logic                 illegal,
    output logic [2:0]           state
);

    localparam bit c_RV64 = (XLEN == 64);

    // ALU function codes; values track the shared TYPES ALU macros
    localparam logic [ALU_SEL_W-1:0] c_ALU_ADD   = ALU_SEL_W'(0);
    localparam logic [ALU_SEL_W-1:0] c_ALU_SUB   = ALU_SEL_W'(1);
    localparam logic [ALU_SEL_W-1:0] c_ALU_SLL   = ALU_SEL_W'(2);
    localparam logic [ALU_SEL_W-1:0] c_ALU_SLT   = ALU_SEL_W'(3);
    localparam logic [ALU_SEL_W-1:0] c_ALU_SLTU  = ALU_SEL_W'(4);
    localparam logic [ALU_SEL_W-1:0] c_ALU_XOR   = ALU_SEL_W'(5);
    localparam logic [ALU_SEL_W-1:0] c_ALU_SRL   = ALU_SEL_W'(6);
    localparam logic [ALU_SEL_W-1:0] c_ALU_SRA   = ALU_SEL_W'(7);
    localparam logic [ALU_SEL_W-1:0] c_ALU_OR    = ALU_SEL_W'(8);
    localparam logic [ALU_SEL_W-1:0] c_ALU_AND   = ALU_SEL_W'(9);
    localparam logic [ALU_SEL_W-1:0] c_ALU_PASSB = ALU_SEL_W'(10);

    // Immediate type codes
    localparam logic [2:0] c_IMM_I = 3'd0;
    localparam logic [2:0] c_IMM_U = 3'd1;
    localparam logic [2:0] c_IMM_B = 3'd2;
    localparam logic [2:0] c_IMM_S = 3'd3;
    localparam logic [2:0] c_IMM_J = 3'd4;

    // Major opcodes
    localparam logic [6:0] c_OPC_LUI      = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL      = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR     = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE    = 7'b0100011;
    localparam logic [6:0] c_OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_OP       = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] c_OPC_OP32     = 7'b0111011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0] r_inst;
    logic        r_wreg;       // instruction writes the regfile in WB
    logic        r_mdu_busy;   // past the first EXEC cycle of an MDU op

    logic [6:0]           w_opcode;
    logic [2:0]           w_funct3;
    logic [6:0]           w_funct7;
    logic                 w_rtype;
    logic                 w_unused_fields;
    logic [ALU_SEL_W-1:0] w_f3_sel;
    logic [ALU_SEL_W-1:0] w_br_sel;
    logic [2:0]           w_imm;
    logic                 w_asrc;
    logic [1:0]           w_bsrc;
    logic [ALU_SEL_W-1:0] w_sel;
    logic                 w_branch;
    logic                 w_load;
    logic                 w_store;
    logic                 w_word;
    logic                 w_mdu;
    logic                 w_wreg;
    logic                 w_bad;

    assign w_opcode        = r_inst[6:0];
    assign w_funct3        = r_inst[14:12];
    assign w_funct7        = r_inst[31:25];
    assign w_rtype         = (w_opcode == c_OPC_OP) || (w_opcode == c_OPC_OP32);
    // Register and immediate fields belong to the datapath, not to control
    assign w_unused_fields = ^{r_inst[24:15], r_inst[11:7]};
    assign w_br_sel        = (w_funct3[2] & w_funct3[1]) ? c_ALU_SLTU :
                             (w_funct3[2] ^ w_funct3[1]) ? c_ALU_SLT  : c_ALU_SUB;
    assign state           = r_state;

    // ALU function from funct3 for OP/OP-IMM and their word forms
    always_comb begin
        w_f3_sel = c_ALU_ADD;
        case (w_funct3)
            3'b000:  w_f3_sel = (w_rtype && w_funct7[5]) ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  w_f3_sel = c_ALU_SLL;
            3'b010:  w_f3_sel = c_ALU_SLT;
            3'b011:  w_f3_sel = c_ALU_SLTU;
            3'b100:  w_f3_sel = c_ALU_XOR;
            3'b101:  w_f3_sel = w_funct7[5] ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  w_f3_sel = c_ALU_OR;
            default: w_f3_sel = c_ALU_AND;
        endcase
    end

    // Decode the latched instruction into the static control bundle
    always_comb begin
        w_imm    = c_IMM_I;
        w_asrc   = 1'b0;
        w_bsrc   = 2'b00;
        w_sel    = c_ALU_ADD;
        w_branch = 1'b0;
        w_load   = 1'b0;
        w_store  = 1'b0;
        w_word   = 1'b0;
        w_mdu    = 1'b0;
        w_wreg   = 1'b0;
        w_bad    = 1'b0;
        case (w_opcode)
            c_OPC_LUI: begin
                w_imm = c_IMM_U; w_bsrc = 2'b01; w_sel = c_ALU_PASSB; w_wreg = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_imm = c_IMM_U; w_asrc = 1'b1; w_bsrc = 2'b01; w_wreg = 1'b1;
            end
            c_OPC_JAL: begin
                w_imm = c_IMM_J; w_asrc = 1'b1; w_bsrc = 2'b10; w_wreg = 1'b1;
            end
            c_OPC_JALR: begin
                w_imm = c_IMM_I; w_asrc = 1'b1; w_bsrc = 2'b10; w_wreg = 1'b1;
            end
            c_OPC_BRANCH: begin
                w_imm = c_IMM_B; w_sel = w_br_sel; w_branch = 1'b1;
            end
            c_OPC_LOAD: begin
                w_imm = c_IMM_I; w_bsrc = 2'b01; w_load = 1'b1; w_wreg = 1'b1;
            end
            c_OPC_STORE: begin
                w_imm = c_IMM_S; w_bsrc = 2'b01; w_store = 1'b1;
            end
            c_OPC_OP_IMM, c_OPC_OP_IMM32: begin
                w_bsrc = 2'b01;
                w_sel  = w_f3_sel;
                w_wreg = 1'b1;
                w_word = (w_opcode == c_OPC_OP_IMM32);
                w_bad  = w_word && !c_RV64;
            end
            c_OPC_OP, c_OPC_OP32: begin
                w_sel  = w_f3_sel;
                w_wreg = 1'b1;
                w_word = (w_opcode == c_OPC_OP32);
                w_bad  = w_word && !c_RV64;
                case (w_funct7)
                    7'b0000000: ;
                    7'b0100000: begin
                        if ((w_funct3 != 3'b000) && (w_funct3 != 3'b101)) w_bad = 1'b1;
                    end
                    7'b0000001: begin
                        if (EN_M) w_mdu = 1'b1;
                        else      w_bad = 1'b1;
                    end
                    default: w_bad = 1'b1;
                endcase
            end
            default: w_bad = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Instruction latch, static control outputs and MDU first-cycle tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inst      <= '0;
            r_wreg      <= 1'b0;
            r_mdu_busy  <= 1'b0;
            op_IMM      <= '0;
            op_ALU_Asrc <= 1'b0;
            op_ALU_Bsrc <= '0;
            op_ALU_sel  <= '0;
            branch      <= 1'b0;
            load        <= 1'b0;
            en_Wmem     <= 1'b0;
            word_op     <= 1'b0;
            mdu_op      <= 1'b0;
            mdu_fn      <= '0;
        end else begin
            if ((r_state == S_FETCH) && ifu_rvalid) r_inst <= inst;
            if (r_state == S_DECODE) begin
                r_wreg      <= w_wreg;
                op_IMM      <= w_imm;
                op_ALU_Asrc <= w_asrc;
                op_ALU_Bsrc <= w_bsrc;
                op_ALU_sel  <= w_sel;
                branch      <= w_branch;
                load        <= w_load;
                en_Wmem     <= w_store;
                word_op     <= w_word;
                mdu_op      <= w_mdu;
                mdu_fn      <= w_funct3;
            end
            r_mdu_busy <= (r_state == S_EXEC) && (w_state_nxt == S_EXEC);
        end
    end

    // Next-state and handshake/strobe outputs
    always_comb begin
        w_state_nxt = r_state;
        ifu_req     = 1'b0;
        lsu_req     = 1'b0;
        lsu_wen     = 1'b0;
        exu_start   = 1'b0;
        en_Wreg     = 1'b0;
        pc_we       = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_FETCH;
            S_FETCH: begin
                ifu_req = 1'b1;
                if (ifu_rvalid) w_state_nxt = S_DECODE;
            end
            S_DECODE: w_state_nxt = w_bad ? S_TRAP : S_EXEC;
            S_EXEC: begin
                exu_start = mdu_op && !r_mdu_busy;
                if (!mdu_op || exu_done)
                    w_state_nxt = (load || en_Wmem) ? S_MEM : S_WB;
            end
            S_MEM: begin
                lsu_req = 1'b1;
                lsu_wen = en_Wmem;
                if (lsu_rvalid) w_state_nxt = S_WB;
            end
            S_WB: begin
                pc_we       = 1'b1;
                en_Wreg     = r_wreg;
                w_state_nxt = S_FETCH;
            end
            S_TRAP: illegal = 1'b1;
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
